// File: rtl/a7_link_ctrl.sv
// a7_link_ctrl: request/response controller for the single-wire serialized
// register bus between the Microzed PS side and the Artix7.
// A request is sent as framed 9-bit bytes (0,1,F,d7..d0,0,0, MSB first,
// F marks the command byte). The controller then waits for a flagged
// response byte whose two preceding data bytes carry the read data.
module a7_link_ctrl #(
  parameter int          TIMEOUT   = 1024,     // WAIT_RESP cycles before giving up
  parameter logic [7:0]  CMD_WR    = 8'h01,
  parameter logic [7:0]  CMD_RD    = 8'h02,
  parameter logic [15:0] SENT_INIT = 16'h0000  // reset value of bytes_sent
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wrdata,
  output logic        rsp_valid,
  output logic        rsp_timeout,
  output logic [15:0] rsp_rddata,
  output logic [7:0]  rsp_status,
  output logic        serial_out,
  input  logic        serial_in,
  output logic        busy,
  output logic [15:0] bytes_sent,
  output logic [15:0] bytes_seen
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RESP, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        accept;
  logic [64:0] seq_ld;
  logic [64:0] tx_sh;
  logic [6:0]  tx_left;
  logic        tx_done;
  logic [15:0] to_cnt;
  logic        to_hit;
  logic        rx_q;
  logic [11:0] rx_sh;
  logic        rx_det;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic [15:0] acc;
  logic        resp_hit;

  // One 13-bit frame on the wire: start pair 0,1, flag, data, two stop zeros.
  function automatic logic [12:0] frame_byte(input logic flag, input logic [7:0] d);
    return {2'b01, flag, d, 2'b00};
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = req_valid & req_ready;
  assign tx_done   = (state == SHIFT) && (tx_left == 7'd0);
  assign to_hit    = (state == WAIT_RESP) && (to_cnt == TO_LAST);

  // A byte sits in the window once the start '1' reached the top and both
  // stop zeros are in; the leading '0' has already fallen off.
  assign rx_det   = rx_sh[11] & (rx_sh[1:0] == 2'b00);
  assign rx_flag  = rx_sh[10];
  assign rx_data  = rx_sh[9:2];
  assign resp_hit = (state == WAIT_RESP) && rx_det && rx_flag;

  // Outgoing sequence, left-aligned; a read leaves the low 26 bits unused.
  always_comb begin
    seq_ld = '0;
    if (req_write)
      seq_ld = {frame_byte(1'b0, req_wrdata[15:8]), frame_byte(1'b0, req_wrdata[7:0]),
                frame_byte(1'b0, req_addr[15:8]),   frame_byte(1'b0, req_addr[7:0]),
                frame_byte(1'b1, CMD_WR)};
    else
      seq_ld = {frame_byte(1'b0, req_addr[15:8]), frame_byte(1'b0, req_addr[7:0]),
                frame_byte(1'b1, CMD_RD), 26'd0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; a flagged byte on the timeout edge still counts as a response.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = SHIFT;
      SHIFT:     if (tx_done) state_nx = WAIT_RESP;
      WAIT_RESP: if (resp_hit || to_hit) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Transmitter: bit 0 goes out on the acceptance edge, the rest follow,
  // and the line parks low whenever nothing is being shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh      <= '0;
      tx_left    <= '0;
      serial_out <= 1'b0;
    end else if (accept) begin
      serial_out <= seq_ld[64];
      tx_sh      <= {seq_ld[63:0], 1'b0};
      tx_left    <= req_write ? 7'd64 : 7'd38;
    end else if (state == SHIFT && tx_left != 7'd0) begin
      serial_out <= tx_sh[64];
      tx_sh      <= {tx_sh[63:0], 1'b0};
      tx_left    <= tx_left - 7'd1;
    end else begin
      serial_out <= 1'b0;
    end
  end

  // Byte counter for transmitted bytes, bumped by the whole request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bytes_sent <= SENT_INIT;
    else if (accept) bytes_sent <= bytes_sent + (req_write ? 16'd5 : 16'd3);
  end

  // Response timer: zero outside WAIT_RESP, counts every cycle inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (state != WAIT_RESP) to_cnt <= '0;
    else                         to_cnt <= to_cnt + 16'd1;
  end

  // Receiver: one sync flop, then a 12-bit window that clears on each byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= 1'b0;
      rx_sh      <= '0;
      bytes_seen <= '0;
    end else begin
      rx_q       <= serial_in;
      rx_sh      <= rx_det ? 12'd0 : {rx_sh[10:0], rx_q};
      bytes_seen <= bytes_seen + {15'd0, rx_det};
    end
  end

  // Data accumulator; only the two most recent data bytes are ever observable.
  // Cleared on entry to WAIT_RESP so stale traffic cannot leak into a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (tx_done) acc <= '0;
    else if (rx_det) acc <= rx_flag ? 16'd0 : {acc[7:0], rx_data};
  end

  // Completion results; on timeout the previous data/status are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_timeout <= 1'b0;
      rsp_rddata  <= '0;
      rsp_status  <= '0;
    end else if (resp_hit) begin
      rsp_timeout <= 1'b0;
      rsp_rddata  <= acc;
      rsp_status  <= rx_data;
    end else if (to_hit) begin
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_a7_link_ctrl.sv
// Bench for a7_link_ctrl: directed requests, a serial stub on serial_in,
// and a negedge monitor that checks serial_out bits and rsp pulses against
// queues filled by the stimulus.
module tb_a7_link_ctrl;
  localparam int T1 = 64;   // main instance: room for a 3-byte response
  localparam int T2 = 16;   // second instance: short timeout, preset counter

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req_valid = 1'b0, req_valid2 = 1'b0;
  logic req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wrdata = '0;
  logic serial_in = 1'b0, serial_in2 = 1'b0;
  logic req_ready, rsp_valid, rsp_timeout, serial_out, busy;
  logic [15:0] rsp_rddata, bytes_sent, bytes_seen;
  logic [7:0] rsp_status;
  logic req_ready2, rsp_valid2, rsp_timeout2, serial_out2, busy2;
  logic [15:0] rsp_rddata2, bytes_sent2, bytes_seen2;
  logic [7:0] rsp_status2;

  always #5 clk = ~clk;

  a7_link_ctrl #(.TIMEOUT(T1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid), .rsp_timeout(rsp_timeout), .rsp_rddata(rsp_rddata),
    .rsp_status(rsp_status), .serial_out(serial_out), .serial_in(serial_in),
    .busy(busy), .bytes_sent(bytes_sent), .bytes_seen(bytes_seen));

  a7_link_ctrl #(.TIMEOUT(T2), .SENT_INIT(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_wrdata(req_wrdata),
    .rsp_valid(rsp_valid2), .rsp_timeout(rsp_timeout2), .rsp_rddata(rsp_rddata2),
    .rsp_status(rsp_status2), .serial_out(serial_out2), .serial_in(serial_in2),
    .busy(busy2), .bytes_sent(bytes_sent2), .bytes_seen(bytes_seen2));

  typedef struct {
    logic        to;
    logic [15:0] rd;
    logic [7:0]  st;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_bits[$];
  int   exp_len[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   rsp2_cnt = 0;
  int   rsp2_cyc = -1;
  logic rsp2_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge counter: at a negedge or #1 after an edge, cyc is the index of the last edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic push_frame(input bit f, input logic [7:0] d);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    exp_bits.push_back(f);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
  endtask

  // Expected line contents for one request, plus the idle 0 after the last bit.
  task automatic push_seq(input bit wr, input logic [15:0] a, input logic [15:0] d);
    if (wr) begin
      push_frame(1'b0, d[15:8]); push_frame(1'b0, d[7:0]);
      push_frame(1'b0, a[15:8]); push_frame(1'b0, a[7:0]);
      push_frame(1'b1, 8'h01);
      exp_len.push_back(66);
    end else begin
      push_frame(1'b0, a[15:8]); push_frame(1'b0, a[7:0]);
      push_frame(1'b1, 8'h02);
      exp_len.push_back(40);
    end
    exp_bits.push_back(1'b0);
  endtask

  // Monitor: serial_out bits after each acceptance, and every rsp pulse.
  initial forever begin
    exp_t e;
    int tx_left;
    @(negedge clk);
    if (!rst_n) begin
      exp_bits.delete();
      tx_left = 0;
    end else begin
      if (tx_left > 0) begin
        if (exp_bits.size() > 0) check("serial_out", {31'd0, serial_out}, {31'd0, exp_bits.pop_front()});
        tx_left--;
      end
      if (req_valid && req_ready) begin
        acc_cnt++;
        if (exp_len.size() == 0) check("unexpected_accept", 32'd1, 32'd0);
        else tx_left = exp_len.pop_front();
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
          check("rsp_rddata", {16'd0, rsp_rddata}, {16'd0, e.rd});
          check("rsp_status", {24'd0, rsp_status}, {24'd0, e.st});
          check("rsp_cycle", cyc, e.cyc);
        end
      end
      if (rsp_valid2) begin
        rsp2_cnt++;
        rsp2_cyc = cyc;
        rsp2_to  = rsp_timeout2;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request and return the acceptance edge; optionally leave valid high.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit push, input bit keep, output int acc_edge);
    bit ok;
    ok = 1'b0;
    req_write = wr; req_addr = a; req_wrdata = d;
    if (push) push_seq(wr, a, d);
    req_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_wait", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    acc_edge = cyc;
    if (!keep) req_valid = 1'b0;
  endtask

  // Stub transmitter on serial_in: one frame bit per cycle, starting now.
  task automatic send_byte(input bit f, input logic [7:0] d);
    logic [12:0] fr;
    fr = {2'b01, f, d, 2'b00};
    for (int j = 12; j >= 0; j--) begin
      serial_in = fr[j];
      @(posedge clk);
      #1;
    end
    serial_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, e2, acc0;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // reset state
    check("rst_serial_out", {31'd0, serial_out}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    check("rst_rsp_rddata", {16'd0, rsp_rddata}, 32'd0);
    check("rst_rsp_status", {24'd0, rsp_status}, 32'd0);
    check("rst_bytes_sent", {16'd0, bytes_sent}, 32'd0);
    check("rst_bytes_seen", {16'd0, bytes_seen}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_bytes_sent2", {16'd0, bytes_sent2}, 32'h0000FFFE);

    // write 0x1234 -> 0x0003, stub answers 56, 78, flagged 00
    issue(1'b1, 16'h0003, 16'h1234, 1'b1, 1'b0, a);
    check("wr_bytes_sent", {16'd0, bytes_sent}, 32'd5);
    check("wr_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back('{1'b0, 16'h5678, 8'h00, a + 106});
    wait_until(a + 65);
    send_byte(1'b0, 8'h56);
    send_byte(1'b0, 8'h78);
    send_byte(1'b1, 8'h00);
    wait_until(a + 110);
    check("wr_bytes_seen", {16'd0, bytes_seen}, 32'd3);
    check("wr_idle_busy", {31'd0, busy}, 32'd0);

    // read 0x0001, stub silent -> timeout, data/status retained
    issue(1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, a);
    exp_q.push_back('{1'b1, 16'h5678, 8'h00, a + 39 + T1});
    wait_until(a + 39 + T1 + 3);
    check("rd_bytes_sent", {16'd0, bytes_sent}, 32'd8);

    // valid held high; fields changed mid-shift become the second request
    acc0 = acc_cnt;
    issue(1'b1, 16'h00A5, 16'hBEEF, 1'b1, 1'b1, a);
    exp_q.push_back('{1'b1, 16'h5678, 8'h00, a + 65 + T1});
    wait_until(a + 10);
    req_write = 1'b0; req_addr = 16'h4321; req_wrdata = 16'hFFFF;
    push_seq(1'b0, 16'h4321, 16'hFFFF);
    exp_q.push_back('{1'b1, 16'h5678, 8'h00, a + 131 + 39 + T1});
    issue(1'b0, 16'h4321, 16'hFFFF, 1'b0, 1'b0, a2);
    check("second_accept_edge", a2, a + 131);
    wait_until(a2 + 39 + T1 + 3);
    check("held_valid_accepts", acc_cnt - acc0, 32'd2);
    check("held_bytes_sent", {16'd0, bytes_sent}, 32'd16);

    // flagged byte lands on the timeout edge: response wins
    issue(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b0, a);
    exp_q.push_back('{1'b0, 16'h9ABC, 8'h5E, a + 65 + T1});
    wait_until(a + 65 + T1 - 15 - 26);
    send_byte(1'b0, 8'h9A);
    send_byte(1'b0, 8'hBC);
    send_byte(1'b1, 8'h5E);
    wait_until(a + 65 + T1 + 4);
    check("race_bytes_seen", {16'd0, bytes_seen}, 32'd6);

    // stray bytes while idle: counted only
    send_byte(1'b0, 8'h11);
    send_byte(1'b1, 8'h22);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("stray_bytes_seen", {16'd0, bytes_seen}, 32'd8);
    check("stray_rsp_rddata", {16'd0, rsp_rddata}, 32'h9ABC);
    check("stray_rsp_status", {24'd0, rsp_status}, 32'h5E);
    check("stray_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of shifting
    issue(1'b1, 16'h0777, 16'h0F0F, 1'b1, 1'b0, a);
    wait_until(a + 20);
    rst_n = 1'b0;
    #1;
    check("abort_serial_out", {31'd0, serial_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bytes_sent", {16'd0, bytes_sent}, 32'd0);
    check("abort_rsp_rddata", {16'd0, rsp_rddata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fresh transaction after the abort
    issue(1'b1, 16'h0003, 16'h1234, 1'b1, 1'b0, a);
    check("fresh_bytes_sent", {16'd0, bytes_sent}, 32'd5);
    exp_q.push_back('{1'b0, 16'h5678, 8'h00, a + 106});
    wait_until(a + 65);
    send_byte(1'b0, 8'h56);
    send_byte(1'b0, 8'h78);
    send_byte(1'b1, 8'h00);
    wait_until(a + 110);
    check("fresh_bytes_seen", {16'd0, bytes_seen}, 32'd3);

    // preset counter wraps; short timeout lands TIMEOUT cycles into WAIT_RESP
    check("dut2_ready", {31'd0, req_ready2}, 32'd1);
    req_write = 1'b1; req_addr = 16'h0003; req_wrdata = 16'h1234;
    req_valid2 = 1'b1;
    @(posedge clk);
    #1;
    e2 = cyc;
    req_valid2 = 1'b0;
    check("wrap_bytes_sent", {16'd0, bytes_sent2}, 32'h0003);
    wait_until(e2 + 65 + T2 + 3);
    check("t16_rsp_count", rsp2_cnt, 32'd1);
    check("t16_rsp_cycle", rsp2_cyc, e2 + 65 + T2);
    check("t16_rsp_timeout", {31'd0, rsp2_to}, 32'd1);
    check("t16_rsp_rddata", {16'd0, rsp_rddata2}, 32'd0);

    check("pending_rsp", exp_q.size(), 32'd0);
    check("pending_accept", exp_len.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
